mister_lbuf_fill: RTL and testbench

- Line-buffer writer for the MiSTer X68000 video path.
- On each line-start pulse, it fetches one scanline of 16-bit GRBI pixels from graphic VRAM over a req/ack handshake.
- It writes those pixels into the LRAM bank that scan-out is not currently reading, so scan-out can display them on the following line.
- For non-visible lines it clears the bank to zero instead.

---
 rtl/mister_video_pkg.sv | 31 +++
 rtl/mister_lbuf_addr.sv | 32 +++
 rtl/mister_lbuf_fill.sv | 179 +++++++++++++++++
 tb/tb_mister_lbuf_fill.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mister_video_pkg.sv
// Shared definitions for the X68000 video path: fill FSM states, GRBI pixel
// layout (also used by scan-out) and the default line-buffer depth.
package mister_video_pkg;

  localparam int LAWIDTH_DEF = 10;

  // GRBI pixel word: {G5, R5, B5, I}
  localparam int GRBI_G_MSB = 15;
  localparam int GRBI_G_LSB = 11;
  localparam int GRBI_R_MSB = 10;
  localparam int GRBI_R_LSB = 6;
  localparam int GRBI_B_MSB = 5;
  localparam int GRBI_B_LSB = 1;
  localparam int GRBI_I_BIT = 0;

  typedef struct packed {
    logic [4:0] g;
    logic [4:0] r;
    logic [4:0] b;
    logic       i;
  } grbi_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WRITE = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } lbuf_state_e;

endpackage

// File: rtl/mister_lbuf_addr.sv
// Line start address generator: registers base + vline*stride when a fill
// is accepted, so the fetch FSM sees a stable line address for the whole line.
module mister_lbuf_addr #(
  parameter int VAWIDTH = 19
) (
  input  logic               gclk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [VAWIDTH-1:0] i_base,
  input  logic [9:0]         i_vline,
  input  logic [9:0]         i_stride,
  output logic [VAWIDTH-1:0] o_line_addr
);

  logic [VAWIDTH-1:0] w_prod;
  logic [VAWIDTH-1:0] r_line_addr;

  // Multiplying at VAWIDTH bits keeps exactly the low bits of the 20-bit product.
  assign w_prod = VAWIDTH'(i_vline) * VAWIDTH'(i_stride);

  // NOTE: registers are updated with <= so every flop samples pre-edge values.
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_line_addr <= '0;
    end else if (i_load) begin
      r_line_addr <= i_base + w_prod;
    end
  end

  assign o_line_addr = r_line_addr;

endmodule

// File: rtl/mister_lbuf_fill.sv
// Line-buffer writer: on each line start, fetches one scanline from VRAM into
// the LRAM bank not being displayed, or clears that bank for blank lines.
module mister_lbuf_fill
  import mister_video_pkg::*;
#(
  parameter int LAWIDTH = LAWIDTH_DEF,
  parameter int VAWIDTH = 19
) (
  input  logic               gclk,
  input  logic               rst,
  input  logic               line_start,
  input  logic               lsel,
  input  logic               line_en,
  input  logic [9:0]         vline,
  input  logic [7:0]         hdots8,
  input  logic [VAWIDTH-1:0] base_addr,
  input  logic [9:0]         stride,
  output logic               vram_req,
  output logic [VAWIDTH-1:0] vram_addr,
  input  logic               vram_ack,
  input  logic [15:0]        vram_rdat,
  output logic               lram_we,
  output logic               lram_sel,
  output logic [LAWIDTH-1:0] lram_adr,
  output logic [15:0]        lram_wdat,
  output logic               busy,
  output logic               fill_done,
  output logic               overrun
);

  // One extra index bit lets a full-depth line terminate without wrapping to 0.
  localparam int NW    = LAWIDTH + 1;
  localparam int DEPTH = 1 << LAWIDTH;

  lbuf_state_e        r_state;
  logic [NW-1:0]      r_idx;
  logic [NW-1:0]      r_npix;
  logic               r_wsel;
  logic               r_req;
  logic               r_we;
  logic [LAWIDTH-1:0] r_adr;
  grbi_t              r_wdat;
  logic               r_done;
  logic               r_ovr;
  logic               r_busy;

  logic [10:0]        w_npix_raw;
  logic [NW-1:0]      w_npix;
  logic [NW-1:0]      w_idx_nxt;
  logic [VAWIDTH-1:0] w_line_addr;
  logic               w_active;

  mister_lbuf_addr #(
    .VAWIDTH (VAWIDTH)
  ) u_addr (
    .gclk        (gclk),
    .rst         (rst),
    .i_load      (line_start),
    .i_base      (base_addr),
    .i_vline     (vline),
    .i_stride    (stride),
    .o_line_addr (w_line_addr)
  );

  assign w_npix_raw = {hdots8, 3'b000};
  assign w_idx_nxt  = r_idx + NW'(1);
  // A fill still owns the bank; DONE is excluded so back-to-back lines never overrun.
  assign w_active   = (r_state == S_FETCH) || (r_state == S_WRITE) || (r_state == S_CLEAR);

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_npix = NW'(w_npix_raw);
    if (int'(w_npix_raw) > DEPTH) begin
      w_npix = NW'(DEPTH);
    end
  end

  // NOTE: reset is synchronous; it wins over every other event in the same cycle.
  always_ff @(posedge gclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_npix  <= '0;
      r_wsel  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_ovr  <= 1'b0;
      if (line_start) begin
        // Accept always wins; an in-flight fill is abandoned and flagged.
        r_ovr  <= w_active;
        r_wsel <= ~lsel;
        r_npix <= w_npix;
        r_idx  <= '0;
        r_adr  <= '0;
        r_wdat <= '0;
        r_busy <= 1'b1;
        if (w_npix == '0) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
          r_req   <= 1'b0;
          r_we    <= 1'b0;
        end else if (line_en) begin
          r_state <= S_FETCH;
          // After an abandoned fill, req drops for a cycle so the address change is visible.
          r_req   <= ~w_active;
          r_we    <= 1'b0;
        end else begin
          r_state <= S_CLEAR;
          r_req   <= 1'b0;
          r_we    <= 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            r_busy <= 1'b0;
          end
          S_FETCH: begin
            if (!r_req) begin
              r_req <= 1'b1;
            end else if (vram_ack) begin
              r_req   <= 1'b0;
              r_we    <= 1'b1;
              r_adr   <= r_idx[LAWIDTH-1:0];
              r_wdat  <= grbi_t'(vram_rdat);
              r_state <= S_WRITE;
            end
          end
          S_WRITE: begin
            r_we  <= 1'b0;
            r_idx <= w_idx_nxt;
            if (w_idx_nxt == r_npix) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              r_req   <= 1'b1;
            end
          end
          S_CLEAR: begin
            r_idx <= w_idx_nxt;
            if (r_idx == r_npix - NW'(1)) begin
              r_we    <= 1'b0;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_adr <= w_idx_nxt[LAWIDTH-1:0];
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign vram_req  = r_req;
  assign vram_addr = w_line_addr + VAWIDTH'(r_idx);
  assign lram_we   = r_we;
  assign lram_sel  = r_wsel;
  assign lram_adr  = r_adr;
  assign lram_wdat = r_wdat;
  assign busy      = r_busy;
  assign fill_done = r_done;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_mister_lbuf_fill.sv
// Bench for mister_lbuf_fill: randomized VRAM responder, a transaction-level
// model checked every cycle, and literal expectations for the directed cases.
module tb_mister_lbuf_fill;

  localparam int DEPTH = 1024;
  localparam int VSPAN = 1 << 19;

  logic        gclk = 1'b0;
  logic        rst;
  logic        line_start;
  logic        lsel;
  logic        line_en;
  logic [9:0]  vline;
  logic [7:0]  hdots8;
  logic [18:0] base_addr;
  logic [9:0]  stride;
  logic        vram_req;
  logic [18:0] vram_addr;
  logic        vram_ack;
  logic [15:0] vram_rdat;
  logic        lram_we;
  logic        lram_sel;
  logic [9:0]  lram_adr;
  logic [15:0] lram_wdat;
  logic        busy;
  logic        fill_done;
  logic        overrun;

  mister_lbuf_fill #(
    .LAWIDTH (10),
    .VAWIDTH (19)
  ) dut (
    .gclk       (gclk),
    .rst        (rst),
    .line_start (line_start),
    .lsel       (lsel),
    .line_en    (line_en),
    .vline      (vline),
    .hdots8     (hdots8),
    .base_addr  (base_addr),
    .stride     (stride),
    .vram_req   (vram_req),
    .vram_addr  (vram_addr),
    .vram_ack   (vram_ack),
    .vram_rdat  (vram_rdat),
    .lram_we    (lram_we),
    .lram_sel   (lram_sel),
    .lram_adr   (lram_adr),
    .lram_wdat  (lram_wdat),
    .busy       (busy),
    .fill_done  (fill_done),
    .overrun    (overrun)
  );

  always #5 gclk = ~gclk;

  int n_checks = 0;
  int n_errors = 0;

  // responder controls
  int max_wait    = 0;
  bit spurious_en = 0;
  bit ack_hold    = 0;
  bit force_ack   = 0;

  // model of the fill in progress
  bit          m_act, m_fetch, m_wsel, m_wr_due, m_gap;
  bit          m_done_due, m_ovr_due, m_rst_due;
  int          m_k, m_npix, m_laddr;
  logic [15:0] m_wr_data;

  // per-test observations
  int cyc = 0;
  int wr_count, last_wr_adr, last_wr_cyc, last_ack_cyc, done_cnt, done_cyc, ovr_cnt;
  int first_req_addr, last_req_addr, prev_req_addr;
  bit last_wr_sel, req_seen, wrap_seen;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    @(posedge gclk);
    #2;
    wr_count = 0; last_wr_adr = -1; last_wr_cyc = 0; last_ack_cyc = 0;
    done_cnt = 0; done_cyc = 0; ovr_cnt = 0;
    first_req_addr = -1; last_req_addr = -1; prev_req_addr = -1;
    last_wr_sel = 0; req_seen = 0; wrap_seen = 0;
  endtask

  task automatic start_fill(input bit en, input bit sel, input int vl, input int hd,
                            input int base, input int str);
    @(posedge gclk);
    #2;
    line_en    = en;
    lsel       = sel;
    vline      = 10'(vl);
    hdots8     = 8'(hd);
    base_addr  = 19'(base);
    stride     = 10'(str);
    line_start = 1'b1;
    @(posedge gclk);
    #2;
    line_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge gclk);
      #1;
      n++;
    end while (busy !== 1'b0 && n < budget);
    check("idle_within_budget", busy, 1'b0);
  endtask

  // VRAM responder: acks after 0..max_wait stall cycles, optionally with stray acks.
  initial begin : responder
    int wait_cnt;
    wait_cnt  = 0;
    vram_ack  = 1'b0;
    vram_rdat = '0;
    forever begin
      @(posedge gclk);
      #1;
      vram_rdat = 16'($urandom);
      if (force_ack) begin
        vram_ack = 1'b1;
      end else if (vram_req === 1'b1 && !ack_hold) begin
        if (wait_cnt == 0) begin
          vram_ack = 1'b1;
          wait_cnt = int'($urandom_range(max_wait, 0));
        end else begin
          vram_ack = 1'b0;
          wait_cnt--;
        end
      end else begin
        vram_ack = spurious_en && ($urandom_range(3, 0) == 0);
      end
    end
  end

  // Per-cycle compare against the model, then advance the model with this cycle's inputs.
  initial begin : monitor
    bit e_req, e_we, e_busy, was_act, done_next, ovr_next, started;
    int e_addr, raw;
    started = 0;
    m_rst_due = 0;
    forever begin
      @(negedge gclk);
      cyc++;
      e_req  = m_act && m_fetch && !m_wr_due && !m_gap;
      e_we   = m_act && (!m_fetch || m_wr_due);
      e_busy = m_act || m_done_due;
      e_addr = (m_laddr + m_k) % VSPAN;
      if (started) begin
        check("vram_req", vram_req, e_req);
        check("lram_we", lram_we, e_we);
        check("busy", busy, e_busy);
        check("fill_done", fill_done, m_done_due);
        check("overrun", overrun, m_ovr_due);
        check("lram_sel", lram_sel, m_wsel);
        if (m_rst_due) begin
          check("rst_vram_addr", vram_addr, 0);
          check("rst_lram_adr", lram_adr, 0);
          check("rst_lram_wdat", lram_wdat, 0);
        end
        if (e_req) check("vram_addr", vram_addr, e_addr);
        if (e_we) begin
          check("lram_adr", lram_adr, m_k);
          check("lram_wdat", lram_wdat, m_fetch ? 32'(m_wr_data) : 32'd0);
        end
        if (lram_we === 1'b1) begin
          wr_count++; last_wr_adr = lram_adr; last_wr_sel = lram_sel; last_wr_cyc = cyc;
        end
        if (vram_req === 1'b1) begin
          if (!req_seen) first_req_addr = vram_addr;
          if (req_seen && prev_req_addr == 32'h7FFFF && vram_addr == 0) wrap_seen = 1;
          req_seen = 1; prev_req_addr = vram_addr; last_req_addr = vram_addr;
          if (vram_ack === 1'b1) last_ack_cyc = cyc;
        end
        if (fill_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (overrun === 1'b1) ovr_cnt++;
      end
      if (rst) begin
        m_act = 0; m_fetch = 0; m_wsel = 0; m_wr_due = 0; m_gap = 0;
        m_done_due = 0; m_ovr_due = 0; m_rst_due = 1;
        m_k = 0; m_npix = 0; m_laddr = 0; m_wr_data = '0;
        started = 1;
      end else begin
        m_rst_due = 0; was_act = m_act; done_next = 0; ovr_next = 0;
        if (m_act) begin
          if (e_we) begin
            m_k++; m_wr_due = 0;
            if (m_k == m_npix) begin m_act = 0; done_next = 1; end
          end else if (e_req && vram_ack === 1'b1) begin
            m_wr_due = 1; m_wr_data = vram_rdat;
          end
          m_gap = 0;
        end
        if (line_start) begin
          ovr_next  = was_act;
          raw       = int'(hdots8) * 8;
          m_npix    = (raw > DEPTH) ? DEPTH : raw;
          m_wsel    = ~lsel;
          m_fetch   = line_en;
          m_laddr   = (int'(base_addr) + ((int'(vline) * int'(stride)) % (1 << 20))) % VSPAN;
          m_k       = 0;
          m_wr_due  = 0;
          m_act     = (m_npix != 0);
          done_next = (m_npix == 0);
          m_gap     = ovr_next && line_en;
        end
        m_done_due = done_next;
        m_ovr_due  = ovr_next;
      end
    end
  end

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst = 1'b1; line_start = 1'b0; lsel = 1'b0; line_en = 1'b0;
    vline = '0; hdots8 = '0; base_addr = '0; stride = '0;
    repeat (3) @(posedge gclk);
    #2 rst = 1'b0;

    // Zero-wait fetch of 16 pixels starting at word 3*64.
    clear_stats();
    start_fill(1, 0, 3, 2, 0, 64);
    wait_idle(200);
    check("t1_first_addr", first_req_addr, 192);
    check("t1_last_addr", last_req_addr, 207);
    check("t1_writes", wr_count, 16);
    check("t1_last_adr", last_wr_adr, 15);
    check("t1_wsel", last_wr_sel, 1);
    check("t1_done_after_ack", done_cyc - last_ack_cyc, 2);

    // Clear fill of the whole bank 0.
    clear_stats();
    start_fill(0, 1, 7, 128, 0, 0);
    wait_idle(1200);
    check("t3_writes", wr_count, 1024);
    check("t3_wsel", last_wr_sel, 0);
    check("t3_last_adr", last_wr_adr, 1023);
    check("t3_done_after_wr", done_cyc - last_wr_cyc, 1);

    // Random fills with stalls and stray acks; some lines start early.
    max_wait = 5;
    spurious_en = 1;
    for (int i = 0; i < 10; i++) begin
      start_fill($urandom_range(3, 0) != 0, 1'($urandom), int'($urandom_range(1023, 0)),
                 int'($urandom_range(6, 0)), int'($urandom_range(VSPAN - 1, 0)),
                 int'($urandom_range(1023, 0)));
      if (i % 3 == 2) begin
        repeat ($urandom_range(12, 2)) @(posedge gclk);
        start_fill($urandom_range(1, 0) != 0, 1'($urandom), int'($urandom_range(1023, 0)),
                   int'($urandom_range(4, 1)), int'($urandom_range(VSPAN - 1, 0)),
                   int'($urandom_range(1023, 0)));
      end
      wait_idle(2000);
    end
    spurious_en = 0;
    max_wait = 0;

    // Overrun after 5 pixels; the new line (vline 5, 8 pixels) replaces the old one.
    clear_stats();
    start_fill(1, 0, 2, 4, 100, 10);
    n = 0;
    do begin
      @(negedge gclk);
      #1;
      n++;
    end while (wr_count < 5 && n < 200);
    check("t4_reached_5_writes", wr_count, 5);
    start_fill(1, 0, 5, 1, 100, 10);
    wait_idle(200);
    check("t4_overrun_pulses", ovr_cnt, 1);
    check("t4_writes", wr_count, 13);
    check("t4_last_addr", last_req_addr, 157);

    // Clamped full line whose addresses wrap the VRAM space.
    clear_stats();
    start_fill(1, 1, 0, 200, 19'h7FFF0, 0);
    wait_idle(2200);
    check("t5_writes", wr_count, 1024);
    check("t5_addr_wrapped", wrap_seen, 1);

    // Reset mid-fetch with acks arriving afterwards, then an empty line.
    clear_stats();
    ack_hold = 1;
    start_fill(1, 0, 1, 1, 0, 4);
    repeat (3) @(posedge gclk);
    #2 rst = 1'b1;
    force_ack = 1;
    @(posedge gclk);
    #2 rst = 1'b0;
    @(negedge gclk);
    #1;
    check("t6_busy_after_rst", busy, 0);
    check("t6_req_after_rst", vram_req, 0);
    repeat (2) @(posedge gclk);
    #2 force_ack = 0;
    ack_hold = 0;
    @(negedge gclk);
    #1;
    check("t6_no_writes", wr_count, 0);
    clear_stats();
    start_fill(1, 0, 9, 0, 0, 4);
    wait_idle(20);
    check("t6_empty_done", done_cnt, 1);
    check("t6_empty_writes", wr_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
